// File: rtl/tdm_mux_pkg.sv
// rtl/tdm_mux_pkg.sv - shared constants and controller states for the 4:1 tdm mux/demux pair
package tdm_mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/arb_4_v.sv
// rtl/arb_4_v.sv - 4-way arbiter; round-robin from ptr with TDM_MUX_4_1_RR_EN, fixed priority a>b>c>d otherwise
module arb_4_v
    import tdm_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] start;

`ifdef TDM_MUX_4_1_RR_EN
    assign start = ptr;
`else
    // Fixed priority ignores the pointer; the search always begins at channel a.
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign start      = CH_A;
`endif

    logic [SEL_W-1:0] k;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = start + SEL_W'(i);
            if (!found && enable && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = k;
            end
        end
    end

endmodule

// File: rtl/tdm_mux_4_1_v.sv
// rtl/tdm_mux_4_1_v.sv - 4:1 tdm mux with chip select and registered tagged output; TDM_MUX_4_1_RR_EN selects round-robin
module tdm_mux_4_1_v
    import tdm_mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_d,
    input  logic [NUM_CH-1:0] i_valid,
    output logic [NUM_CH-1:0] o_ready,
    input  logic              i_cs,
    input  logic              i_n_cs_0,
    input  logic              i_n_cs_1,
    output logic [DATA_W-1:0] o_data,
    output logic [SEL_W-1:0]  o_sel,
    output logic              o_valid,
    input  logic              i_ready
);

    tdm_state_t        state, state_nxt;
    logic              en;
    logic              load;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic [SEL_W-1:0]  ptr;
    logic [DATA_W-1:0] data_sel;

    assign en   = i_cs & ~i_n_cs_0 & ~i_n_cs_1;
    // Reset is folded in here so no producer sees an accept while reset is asserted.
    assign load = en & (~o_valid | i_ready) & ~i_rst;

    arb_4_v u_arb (
        .req       (i_valid),
        .ptr       (ptr),
        .enable    (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any = |grant;
    assign o_ready   = grant;

`ifdef TDM_MUX_4_1_RR_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            ptr <= CH_A;
        else if (grant_any)
            ptr <= grant_idx + SEL_W'(1);
    end
`else
    assign ptr = CH_A;
`endif

    always_comb begin
        data_sel = i_a;
        case (grant_idx)
            CH_A:    data_sel = i_a;
            CH_B:    data_sel = i_b;
            CH_C:    data_sel = i_c;
            default: data_sel = i_d;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (grant_any) state_nxt = ST_FULL;
            ST_FULL:  if (i_ready && !grant_any) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        o_valid = (state == ST_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_sel  <= '0;
        end else if (grant_any) begin
            o_data <= data_sel;
            o_sel  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_tdm_mux_4_1_v.sv
// tb/tb_tdm_mux_4_1_v.sv - directed self-checking bench for tdm_mux_4_1_v (both arbitration builds)
module tb_tdm_mux_4_1_v;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_a, i_b, i_c, i_d;
    logic [3:0] i_valid;
    logic [3:0] o_ready;
    logic       i_cs, i_n_cs_0, i_n_cs_1;
    logic [7:0] o_data;
    logic [1:0] o_sel;
    logic       o_valid;
    logic       i_ready;

    int checks   = 0;
    int failures = 0;

    tdm_mux_4_1_v #(.DATA_W(8)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_c      (i_c),
        .i_d      (i_d),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_cs     (i_cs),
        .i_n_cs_0 (i_n_cs_0),
        .i_n_cs_1 (i_n_cs_1),
        .o_data   (o_data),
        .o_sel    (o_sel),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
        check({tag, ".valid"}, 32'(o_valid), 32'(v));
        check({tag, ".sel"},   32'(o_sel),   32'(s));
        check({tag, ".data"},  32'(o_data),  32'(d));
    endtask

    int g;
    logic rr;

    initial begin
`ifdef TDM_MUX_4_1_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        i_rst = 1'b1; i_cs = 1'b1; i_n_cs_0 = 1'b0; i_n_cs_1 = 1'b0;
        i_a = 8'h11; i_b = 8'h22; i_c = 8'h33; i_d = 8'h44;
        i_valid = 4'b1111; i_ready = 1'b1;
        #1;
        check("rst_ready", 32'(o_ready), 32'h0);
        step();
        check_out("rst", 1'b0, 2'd0, 8'h00);

        // reset mid-stream discards a held word
        i_rst = 1'b0; i_valid = 4'b0001; i_a = 8'h5A; i_ready = 1'b0;
        #1;
        check("load_ready", 32'(o_ready), 32'h1);
        step();
        check_out("held", 1'b1, 2'd0, 8'h5A);
        i_valid = 4'b0000; i_rst = 1'b1;
        step();
        check_out("midrst", 1'b0, 2'd0, 8'h00);
        i_rst = 1'b0; i_a = 8'h11; i_valid = 4'b1111; i_ready = 1'b1;
        #1;
        check("post_rst_grant", 32'(o_ready), 32'h1);

        // streaming all four valid with i_ready held high
        for (int n = 0; n < 8; n++) begin
            g = rr ? (n % 4) : 0;
            check($sformatf("stream%0d_ready", n), 32'(o_ready), 32'(4'b0001 << g));
            step();
            check_out($sformatf("stream%0d", n), 1'b1, 2'(g), 8'(8'h11 * (g + 1)));
        end
        i_valid = 4'b0000;
        step();
        check("drain_valid", 32'(o_valid), 32'h0);

        // backpressure on channel c
        i_valid = 4'b0100; i_ready = 1'b0;
        #1;
        check("bp_load_ready", 32'(o_ready), 32'h4);
        step();
        check_out("bp_load", 1'b1, 2'd2, 8'h33);
        for (int n = 0; n < 3; n++) begin
            check($sformatf("bp%0d_ready", n), 32'(o_ready), 32'h0);
            step();
            check_out($sformatf("bp%0d", n), 1'b1, 2'd2, 8'h33);
        end
        i_c = 8'h3C; i_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(o_ready), 32'h4);
        step();
        check_out("bp_release", 1'b1, 2'd2, 8'h3C);

        // chip select deasserted: held word drains, no new grants
        i_n_cs_0 = 1'b1;
        #1;
        check("cs_off_ready", 32'(o_ready), 32'h0);
        step();
        check("cs_off_drain", 32'(o_valid), 32'h0);
        check("cs_off_ready2", 32'(o_ready), 32'h0);
        step();
        check("cs_off_idle", 32'(o_valid), 32'h0);
        i_n_cs_0 = 1'b0;
        #1;
        check("cs_on_ready", 32'(o_ready), 32'h4);
        step();
        check_out("cs_on", 1'b1, 2'd2, 8'h3C);

        // pointer at 3 with only b valid: wrap past d and a to b
        i_valid = 4'b0010;
        #1;
        check("wrap_ready", 32'(o_ready), 32'h2);
        step();
        check_out("wrap", 1'b1, 2'd1, 8'h22);
        i_valid = 4'b1111;
        #1;
        check("wrap_ptr", 32'(o_ready), rr ? 32'h4 : 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_mux_4_1_v.md
Name: tdm_mux_4_1_v

Overview:
- Sequential 4-to-1 time-division multiplexer, the transmit end feeding the 1-to-4 demultiplexer.
- Arbitrates four producer channels (a, b, c, d) onto one registered output word.
- Emits a 2-bit channel tag alongside each word; downstream drives the demux select from that tag.
- Uses the same chip-select scheme as the demux: one active-high select, two active-low selects.

Parameters:
- DATA_W, 8, width of each channel word and of o_data.

Ports:
- i_clk  in  1  single clock, all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_a  in  DATA_W  channel 0 data.
- i_b  in  DATA_W  channel 1 data.
- i_c  in  DATA_W  channel 2 data.
- i_d  in  DATA_W  channel 3 data.
- i_valid  in  4  per-channel valid; bit k belongs to channel k (a=0 … d=3).
- o_ready  out  4  per-channel accept; a transfer on channel k occurs when i_valid[k] and o_ready[k] are both high at a clock edge.
- i_cs  in  1  active-high chip select.
- i_n_cs_0  in  1  active-low chip select.
- i_n_cs_1  in  1  active-low chip select.
- o_data  out  DATA_W  registered output word.
- o_sel  out  2  channel tag of o_data.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accept; output transfer when o_valid and i_ready are both high.

Behaviour:
- en = i_cs & ~i_n_cs_0 & ~i_n_cs_1.
- Reset (i_rst=1 at an edge):
  - o_valid=0, o_data=0, o_sel=0.
  - Round-robin pointer = 0.
  - o_ready=0 while i_rst is high.
  - Reset mid-transfer discards the held word with no output handshake.
- load = en & (~o_valid | i_ready); the output slot is free or being drained this cycle.
- Grant:
  - g = first k with i_valid[k]=1, searching k = ptr, ptr+1, … modulo 4.
  - o_ready[k] = load & i_valid[k] & (g==k). At most one bit is high; o_ready is combinational from i_valid/en/i_ready.
- On an edge with a granted transfer:
  - o_data <= selected input, o_sel <= g, o_valid <= 1.
  - ptr <= (g+1) mod 4; 3 wraps to 0.
- On an edge with load=1 but no valid input: o_valid <= 0 if draining, otherwise stays 0; ptr unchanged.
- Latency: one cycle from input handshake to o_valid.
- Full throughput: one word per cycle while i_ready stays high.
- Backpressure: o_valid=1 & i_ready=0 means o_data/o_sel hold stable and all o_ready=0.
- en=0: no new grants and all o_ready=0. A held word stays valid until drained. Once drained, o_valid clears, since the load term is then 0 and the drain path still clears valid on i_ready.
- Simultaneous events:
  - Drain and refill in the same edge replaces the word; o_valid stays 1.
  - Several valids in one cycle: only the granted channel transfers; the others must hold their data.
- Two-state controller: EMPTY (o_valid=0) and FULL (o_valid=1).
  - EMPTY→FULL on grant.
  - FULL→EMPTY on i_ready with no grant.
  - FULL→FULL on stall, or on i_ready with a grant.

Optional Feature:
- Macro TDM_MUX_4_1_RR_EN.
- Defined: round-robin grant as described above.
- Undefined: fixed priority a>b>c>d. The search always starts at 0 and ptr logic is removed. A continuously valid channel a starves b, c and d.

Decomposition:
- Package tdm_mux_pkg:
  - NUM_CH=4, SEL_W=2.
  - Channel constants CH_A=0, CH_B=1, CH_C=2, CH_D=3.
  - State enum {ST_EMPTY, ST_FULL}.
  - Shared with the demux bench.
- One sub-module, arb_4_v:
  - Inputs: request vector, ptr, enable.
  - Outputs: one-hot grant and encoded index.
  - Compiles round-robin or fixed priority depending on TDM_MUX_4_1_RR_EN.

Test Plan:
- Reset mid-stream:
  - Stimulus: o_valid=1 holding 0x5A, then i_rst=1 for one edge.
  - Response: o_valid=0, o_data=0, o_sel=0. Next grant with all valid is channel a.
- Round robin (RR_EN defined):
  - Stimulus: i_valid=4'b1111 held, i_ready=1, en=1, i_a..i_d = 0x11, 0x22, 0x33, 0x44.
  - Response: o_sel 0,1,2,3,0 … on consecutive cycles; o_data follows; one-cycle latency.
- Fixed priority (RR_EN undefined):
  - Stimulus: same as round robin.
  - Response: o_sel=0, o_data=0x11 every cycle; o_ready=4'b0001 every cycle.
- Backpressure:
  - Stimulus: word 0x33 on channel c, i_ready=0 for 3 cycles.
  - Response: o_data=0x33, o_sel=2, o_valid=1 stable; o_ready=0. After i_ready=1, next word loads on that edge.
- Chip select:
  - Stimulus: i_n_cs_0=1 with i_valid=4'b0100 while one word is held.
  - Response: held word drains, o_valid then 0, o_ready stays 0. Restoring i_n_cs_0=0 grants channel c.
- Wrap and skip:
  - Stimulus: ptr=3, i_valid=4'b0010.
  - Response: grant channel b (o_sel=1), ptr becomes 2.
